dqn_train_sequencer: RTL and testbench

- Master sequencer for the DQN training datapath.
- Drives the shared 4-bit ctrl and step buses read by the weight1/weight2/weight3 update blocks, the z-layer forward calculators and the backprop/delta unit.
- Runs N training steps per start command. Each step is: forward pass (z1, z2, z3), backprop wait, then one-cycle weight updates for layers 1, 2 and 3.
- Exposes start/busy/done/err handshakes to the top-level episode controller.

---
 rtl/dqn_train_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_dqn_train_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dqn_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dqn_train_sequencer
// Description : Master phase sequencer for the DQN training datapath. Each
//               training step runs forward z1/z2/z3 phases, waits for the
//               backprop unit, then issues one-cycle weight updates for
//               layers 1..3. Drives the shared ctrl/step buses and the
//               start/busy/done/err handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dqn_train_sequencer #(
  parameter int FWD_CYCLES  = 4,   // cycles per forward phase, 1..255
  parameter int BWD_TIMEOUT = 64   // max cycles waiting in BWD, 2..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num_steps,
  input  logic       bwd_done,
  input  logic       abort,
  output logic [3:0] ctrl,
  output logic [3:0] step,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Phase counter is wide enough for the largest legal BWD timeout.
  localparam int          c_cnt_w    = 16;
  localparam logic [15:0] c_fwd_last = 16'(FWD_CYCLES - 1);
  localparam logic [15:0] c_bwd_last = 16'(BWD_TIMEOUT - 1);

  // State encoding is the ctrl bus code itself, so ctrl is the state register.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_UPD_W1 = 4'd1,
    S_UPD_W2 = 4'd2,
    S_UPD_W3 = 4'd3,
    S_FWD_Z1 = 4'd4,
    S_FWD_Z2 = 4'd5,
    S_FWD_Z3 = 4'd6,
    S_BWD    = 4'd7,
    S_DONE   = 4'd9
  } state_t;

  state_t              r_state,  w_state_n;
  logic [c_cnt_w-1:0]  r_cnt,    w_cnt_n;
  logic [3:0]          r_step,   w_step_n;
  logic [3:0]          r_target, w_target_n;
  logic                r_busy,   w_busy_n;
  logic                r_done,   w_done_n;
  logic                r_err,    w_err_n;

  // State and output registers; every output leaves the block registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_step   <= 4'd0;
      r_target <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_step   <= w_step_n;
      r_target <= w_target_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
    end
  end

  // Next-state, step bookkeeping and handshake flags for the following cycle.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_step_n   = r_step;
    w_target_n = r_target;
    w_err_n    = r_err;

    if (r_state != S_IDLE && abort) begin
      // Abort drops straight back to idle; err keeps whatever it held.
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
      w_step_n  = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort in idle suppresses a simultaneous start
          if (start && !abort) begin
            w_state_n  = S_FWD_Z1;
            w_target_n = (num_steps == 4'd0) ? 4'd1 : num_steps;
            w_step_n   = 4'd1;
            w_err_n    = 1'b0;
            w_cnt_n    = '0;
          end
        end

        S_FWD_Z1: begin
          if (r_cnt == c_fwd_last) begin
            w_state_n = S_FWD_Z2;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end

        S_FWD_Z2: begin
          if (r_cnt == c_fwd_last) begin
            w_state_n = S_FWD_Z3;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end

        S_FWD_Z3: begin
          if (r_cnt == c_fwd_last) begin
            w_state_n = S_BWD;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end

        S_BWD: begin
          // bwd_done on the final allowed cycle still counts as success
          if (bwd_done) begin
            w_state_n = S_UPD_W1;
            w_cnt_n   = '0;
          end else if (r_cnt == c_bwd_last) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_step_n  = 4'd0;
            w_err_n   = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end

        S_UPD_W1: w_state_n = S_UPD_W2;

        S_UPD_W2: w_state_n = S_UPD_W3;

        S_UPD_W3: begin
          // target never exceeds 15, so step cannot wrap here
          if (r_step == r_target) begin
            w_state_n = S_DONE;
          end else begin
            w_state_n = S_FWD_Z1;
            w_step_n  = r_step + 4'd1;
          end
        end

        S_DONE: begin
          w_state_n = S_IDLE;
          w_step_n  = 4'd0;
        end

        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_step_n  = 4'd0;
        end
      endcase
    end

    w_busy_n = (w_state_n != S_IDLE);
    w_done_n = (w_state_n == S_DONE);
  end

  assign ctrl = r_state;
  assign step = r_step;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dqn_train_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dqn_train_sequencer
// Description : Self-checking bench for dqn_train_sequencer. A reference model
//               expands each run into its expected per-cycle (ctrl, step, done)
//               trace from the phase rules; randomized runs are compared cycle
//               by cycle along with weight-update shadow counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dqn_train_sequencer;

  localparam int FWD = 2;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_steps = 4'd0;
  logic       bwd_done = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] ctrl;
  logic [3:0] step;
  logic       busy;
  logic       done;
  logic       err;

  dqn_train_sequencer #(.FWD_CYCLES(FWD), .BWD_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_steps (num_steps),
    .bwd_done  (bwd_done),
    .abort     (abort),
    .ctrl      (ctrl),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  typedef struct {
    int ctrl;
    int step;
    bit done;
    bit bwd;    // bench asserts bwd_done during this cycle
  } ent_t;

  ent_t tr[$];
  int   lat[15];          // BWD cycles per step; > TO means never answer
  int   n_vec = 0;
  int   n_err = 0;
  bit   model_err = 1'b0;
  int   busy_cnt, done_cnt, max_step;
  int   w_obs[4];
  int   w_exp[4];

  task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ctrl"}, ctrl, 0);
    chk({tag, ".step"}, step, 0);
    chk({tag, ".busy_done_err"}, {busy, done, err}, {2'b00, model_err});
  endtask

  task automatic push(input int c, input int s, input bit d, input bit b);
    ent_t e;
    e.ctrl = c; e.step = s; e.done = d; e.bwd = b;
    tr.push_back(e);
  endtask

  // Expand one run into its expected cycle trace.
  task automatic build(input logic [3:0] ns, output bit to);
    int t;
    tr.delete();
    to = 1'b0;
    t = (ns == 4'd0) ? 1 : int'(ns);
    for (int s = 1; s <= t && !to; s++) begin
      for (int ph = 4; ph <= 6; ph++)
        for (int c = 0; c < FWD; c++) push(ph, s, 1'b0, 1'b0);
      if (lat[s-1] > TO) begin
        for (int c = 0; c < TO; c++) push(7, s, 1'b0, 1'b0);
        to = 1'b1;
      end else begin
        for (int c = 1; c <= lat[s-1]; c++) push(7, s, 1'b0, c == lat[s-1]);
        push(1, s, 1'b0, 1'b0);
        push(2, s, 1'b0, 1'b0);
        push(3, s, 1'b0, 1'b0);
      end
    end
    if (!to) push(9, t, 1'b1, 1'b0);
  endtask

  // abort_k: -1 none, -2 abort during UPD_W2 of step 3, else trace index.
  // inj_k: trace index at which a start with num_steps=9 is pulsed (ignored).
  task automatic run(input string name, input logic [3:0] ns, input int abort_k_in, input int inj_k);
    bit to;
    bit post_err;
    int abort_k;
    int exp_done;
    build(ns, to);
    abort_k = abort_k_in;
    if (abort_k == -2) begin
      abort_k = -1;
      foreach (tr[i]) if (tr[i].ctrl == 2 && tr[i].step == 3 && abort_k < 0) abort_k = i;
    end
    if (abort_k >= tr.size()) abort_k = -1;
    post_err = to;
    if (abort_k >= 0) begin
      while (tr.size() > abort_k + 1) void'(tr.pop_back());
      post_err = 1'b0;
    end
    for (int l = 0; l < 4; l++) begin w_exp[l] = 0; w_obs[l] = 0; end
    exp_done = 0;
    foreach (tr[i]) begin
      if (tr[i].ctrl >= 1 && tr[i].ctrl <= 3) w_exp[tr[i].ctrl]++;
      if (tr[i].done) exp_done++;
    end
    busy_cnt = 0; done_cnt = 0; max_step = 0;

    num_steps = ns;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_steps = 4'($urandom);
    model_err = 1'b0;

    for (int k = 0; k < tr.size(); k++) begin
      chk($sformatf("%s.c%0d.ctrl", name, k), ctrl, tr[k].ctrl);
      chk($sformatf("%s.c%0d.step", name, k), step, tr[k].step);
      chk($sformatf("%s.c%0d.busy_done_err", name, k), {busy, done, err}, {1'b1, tr[k].done, 1'b0});
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (int'(step) > max_step) max_step = int'(step);
      if (ctrl >= 4'd1 && ctrl <= 4'd3 && step != 4'd0) w_obs[ctrl]++;
      bwd_done = tr[k].bwd ? 1'b1 : ((tr[k].ctrl == 7) ? 1'b0 : 1'($urandom));
      abort = (k == abort_k);
      if (k == inj_k) begin start = 1'b1; num_steps = 4'd9; end
      @(posedge clk); #1;
      bwd_done = 1'b0; abort = 1'b0; start = 1'b0;
    end
    model_err = post_err;
    check_idle({name, ".end"});
    chk({name, ".busy_cycles"}, busy_cnt, tr.size());
    chk({name, ".done_pulses"}, done_cnt, exp_done);
    for (int l = 1; l <= 3; l++) chk($sformatf("%s.w%0d_updates", name, l), w_obs[l], w_exp[l]);
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time bound exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 15; i++) lat[i] = 2;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_reset");

    // Basic run: two steps, bwd_done on the 3rd BWD cycle
    lat[0] = 3; lat[1] = 3;
    run("basic", 4'd2, -1, -1);
    chk("basic.busy_25", busy_cnt, 25);
    chk("basic.done_once", done_cnt, 1);

    // num_steps = 0 behaves as a single step
    lat[0] = 1;
    run("ns0", 4'd0, -1, -1);
    chk("ns0.max_step", max_step, 1);
    chk("ns0.done_once", done_cnt, 1);

    // Timeout in BWD of step 2
    lat[0] = 2; lat[1] = TO + 1;
    run("timeout", 4'd3, -1, -1);
    chk("timeout.no_done", done_cnt, 0);

    // abort together with start in idle: start dropped, err untouched
    abort = 1'b1; start = 1'b1; num_steps = 4'd5;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check_idle("abort_start_idle");
    @(posedge clk); #1;
    check_idle("abort_start_idle2");

    // Next start clears err and runs normally (lat = TO exercises the boundary)
    for (int i = 0; i < 15; i++) lat[i] = 2;
    lat[0] = TO;
    run("recover", 4'd1, -1, -1);

    // Abort during UPD_W2 of step 3
    for (int i = 0; i < 15; i++) lat[i] = 2;
    run("abort_w2", 4'd5, -2, -1);
    chk("abort_w2.w2_total", w_obs[2], 3);
    chk("abort_w2.w3_total", w_obs[3], 2);

    // start pulsed while busy must not change the target
    run("start_busy", 4'd4, -1, 20);
    chk("start_busy.max_step", max_step, 4);

    // start in the DONE cycle is ignored (injected at the last trace entry)
    lat[0] = 1;
    run("start_done", 4'd1, -1, FWD * 3 + 1 + 3);
    @(posedge clk); #1;
    check_idle("start_done.idle2");

    // Asynchronous reset in the middle of FWD_Z2
    num_steps = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && ctrl != 4'd5; i++) begin
      @(posedge clk); #1;
    end
    chk("midreset.reached_z2", ctrl, 5);
    #2;
    rst_n = 1'b0;
    #1;
    model_err = 1'b0;
    check_idle("midreset.async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_idle($sformatf("midreset.hold%0d", i));
    end

    // Randomized runs
    for (int r = 0; r < 14; r++) begin
      logic [3:0] ns;
      int ak;
      int ik;
      ns = 4'($urandom_range(0, 15));
      for (int i = 0; i < 15; i++)
        lat[i] = ($urandom_range(0, 11) == 0) ? TO + 1 : int'($urandom_range(1, TO));
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : -1;
      ik = int'($urandom_range(0, 120));
      run($sformatf("rnd%0d", r), ns, ak, ik);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        check_idle($sformatf("rnd%0d.gap", r));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
